pocket_i2s_rx: RTL

POCKET_I2S_RX -- requirements
Module: pocket_i2s_rx

---
 rtl/pocket_i2s_rx.sv | 125 ++++++++++++
 1 files changed

// File: rtl/pocket_i2s_rx.sv
// pocket_i2s_rx: I2S receiver clocked by audio_sclk. Measures every LRCK slot,
// captures SAMPLE_W bits MSB-first after the one-bit I2S delay, and publishes a
// stereo pair only when both slots of the pair are exactly SLOT_W cycles long.
// Optional feature: define POCKET_I2S_RX_ERR_CNT_EN to build the saturating
// frame-error counter; otherwise err_count is tied to zero.
module pocket_i2s_rx #(
  parameter int unsigned SAMPLE_W  = 16,
  parameter int unsigned SLOT_W    = 32,
  parameter bit          LEFT_LRCK = 1'b1
) (
  input  logic                audio_sclk,
  input  logic                reset,
  input  logic                audio_dac,
  input  logic                audio_lrck,
  output logic [SAMPLE_W-1:0] audio_l,
  output logic [SAMPLE_W-1:0] audio_r,
  output logic                sample_valid,
  output logic                frame_err,
  output logic [7:0]          err_count
);

  localparam logic [5:0] SlotLen = 6'(SLOT_W);
  localparam logic [5:0] LastBit = 6'(SAMPLE_W);
  localparam logic [5:0] IdxMax  = 6'd63;

  typedef enum logic [1:0] {StSync, StLeft, StRight} state_e;

  state_e              state_q;
  logic                lrck_q;
  logic [5:0]          idx_q;
  logic [SAMPLE_W-1:0] shift_q;
  logic [SAMPLE_W-1:0] left_q;

  logic       lrck_edge;
  logic [5:0] idx_cur;
  logic       into_left;
  logic       slot_ok;
  logic       stall;
  logic       err_set;

  // Slot bookkeeping: idx_q holds the index of the current cycle unless an edge
  // restarts it, so at an edge idx_q equals the length of the slot just ended.
  always_comb begin
    lrck_edge = (audio_lrck != lrck_q);
    idx_cur   = lrck_edge ? 6'd0 : idx_q;
    into_left = (audio_lrck == LEFT_LRCK);
    slot_ok   = (idx_q == SlotLen);
    stall     = !lrck_edge && (idx_q == IdxMax) && (state_q != StSync);
    err_set   = stall ||
                (lrck_edge && (state_q == StLeft || state_q == StRight) && !slot_ok);
  end

  // Receiver FSM with its datapath and registered strobes.
  always_ff @(posedge audio_sclk or posedge reset) begin
    if (reset) begin
      state_q      <= StSync;
      lrck_q       <= 1'b0;
      idx_q        <= 6'd0;
      shift_q      <= '0;
      left_q       <= '0;
      audio_l      <= '0;
      audio_r      <= '0;
      sample_valid <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      lrck_q       <= audio_lrck;
      idx_q        <= (idx_cur == IdxMax) ? IdxMax : idx_cur + 6'd1;
      sample_valid <= 1'b0;
      frame_err    <= err_set;

      // Index 0 is the LRCK edge cycle; the MSB follows one cycle later.
      if (lrck_edge) begin
        shift_q <= '0;
      end else if (idx_cur != 6'd0 && idx_cur <= LastBit) begin
        shift_q <= {shift_q[SAMPLE_W-2:0], audio_dac};
      end

      if (stall) begin
        state_q <= StSync;
      end else if (lrck_edge) begin
        unique case (state_q)
          StSync: begin
            if (into_left) state_q <= StLeft;
          end
          StLeft: begin
            // A bad left slot leaves us in a right slot: nothing to pair with.
            if (slot_ok) begin
              left_q  <= shift_q;
              state_q <= StRight;
            end else begin
              state_q <= StSync;
            end
          end
          StRight: begin
            if (slot_ok) begin
              audio_l      <= left_q;
              audio_r      <= shift_q;
              sample_valid <= 1'b1;
            end
            state_q <= StLeft;
          end
          default: state_q <= StSync;
        endcase
      end
    end
  end

`ifdef POCKET_I2S_RX_ERR_CNT_EN
  logic [7:0] err_cnt_q;

  // Saturating count of frame_err pulses, updated alongside frame_err.
  always_ff @(posedge audio_sclk or posedge reset) begin
    if (reset) begin
      err_cnt_q <= 8'd0;
    end else if (err_set && err_cnt_q != 8'hFF) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign err_count = err_cnt_q;
`else
  assign err_count = 8'd0;
`endif

endmodule
